// File: rtl/adder_sched_pkg.sv
// Shared types, constants and the round-robin pick function for adder_sched.
package adder_sched_pkg;

    localparam int SLICE_W  = 16;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Unused requester bits must be zero, so wrapping at MAX_NREQ behaves as wrapping at NREQ.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid, input logic [2:0] ptr);
        pick_t      p;
        logic [2:0] k;
        p = '0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            k = ptr + 3'(i);
            if (valid[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/adder_sched_if.sv
// Requester/response bundle for adder_sched; rsp_ovf exists only when ADDER_SCHED_OVF_EN is defined.
interface adder_sched_if #(
    parameter int NREQ  = 4,
    parameter int WORDS = 4
) ();
    import adder_sched_pkg::*;

    localparam int W   = SLICE_W * WORDS;
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;
`ifdef ADDER_SCHED_OVF_EN
    logic              rsp_ovf;
`endif

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
`ifdef ADDER_SCHED_OVF_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
`ifdef ADDER_SCHED_OVF_EN
        , output rsp_ovf
`endif
    );

endinterface

// File: rtl/adder.sv
// 16-bit adder slice shared by the scheduler datapath.
module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

// File: rtl/adder_sched_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module adder_sched_rr_arb
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);
    pick_t               pick;
    logic [MAX_NREQ-1:0] valid_ext;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, 3'(ptr));
        grant                 = '0;
        gidx                  = IDW'(pick.idx);
        if (pick.found) grant = NREQ'(1) << pick.idx;
    end
endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one 16-bit adder over NREQ multi-slice requests.
// Optional overflow output enabled by ADDER_SCHED_OVF_EN.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WORDS = 4
) (
    input logic          clk,
    input logic          rst_n,
    adder_sched_if.slave bus
);
    localparam int W   = SLICE_W * WORDS;
    localparam int IDW = $clog2(NREQ);
    localparam int SW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t               state;
    logic [IDW-1:0]       ptr, id_q, gidx;
    logic [NREQ-1:0]      grant;
    logic [SW-1:0]        slice;
    logic [W-1:0]         a_q, b_q, sum_q;
    logic                 cin_q, c_q, rsp_valid_q, busy_q;
    logic [SLICE_W-1:0]   add_a, add_b, add_sum;
    logic                 add_cin, add_cout, last_slice;
`ifdef ADDER_SCHED_OVF_EN
    logic                 ovf_q;
`endif

    adder_sched_rr_arb #(.NREQ(NREQ)) u_arb (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    // Grants are offered only in IDLE and are held low while reset is asserted.
    assign bus.req_ready = (rst_n && state == IDLE) ? grant : '0;

    assign add_a      = a_q[slice*SLICE_W +: SLICE_W];
    assign add_b      = b_q[slice*SLICE_W +: SLICE_W];
    assign add_cin    = (slice == '0) ? cin_q : c_q;
    assign last_slice = (slice == SW'(WORDS - 1));

    adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            slice       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADDER_SCHED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        a_q    <= bus.req_a[gidx*W +: W];
                        b_q    <= bus.req_b[gidx*W +: W];
                        cin_q  <= bus.req_cin[gidx];
                        id_q   <= gidx;
                        ptr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        slice  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_q[slice*SLICE_W +: SLICE_W] <= add_sum;
                    c_q                             <= add_cout;
                    if (last_slice) begin
                        slice       <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
`ifdef ADDER_SCHED_OVF_EN
                        ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[SLICE_W-1] != a_q[W-1]);
`endif
                    end else begin
                        slice <= slice + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = c_q;
    assign bus.busy      = busy_q;
`ifdef ADDER_SCHED_OVF_EN
    assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched: vector table, random traffic against an arithmetic model,
// and hand-written round-robin, back-pressure and mid-operation reset sequences.
module tb_adder_sched;
    import adder_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int WORDS = 4;
    localparam int W     = SLICE_W * WORDS;
    localparam int IDW   = $clog2(NREQ);
    localparam int LAT   = WORDS + 1;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0]   sum;
        logic           cout;
        logic [IDW-1:0] id;
        logic           ovf;
        int             lat;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_sched_if #(.NREQ(NREQ), .WORDS(WORDS)) bus ();

    adder_sched #(.NREQ(NREQ), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the full-width sum with carry, as plain arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    // Reference: signed overflow, i.e. the exact signed result does not fit in W bits.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W+1:0] s;
        s = {a[W-1], a[W-1], a} + {b[W-1], b[W-1], b} + (W+2)'(cin);
        return !(s[W+1] == s[W] && s[W] == s[W-1]);
    endfunction

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic load_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_cin[i]      = cin;
        bus.req_valid[i]    = 1'b1;
    endtask

    // Called at a falling edge; returns after the accepting rising edge.
    task automatic do_accept(output int gid);
        gid = -1;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.req_ready != '0) begin
                for (int i = NREQ - 1; i >= 0; i--) if (bus.req_ready[i]) gid = i;
                check("grant_onehot", 128'($countones(bus.req_ready)), 128'd1);
                break;
            end
            @(negedge clk);
        end
        if (gid < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no grant expected a grant within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Counts cycles after the accept edge until rsp_valid is seen.
    task automatic collect(output rsp_t r);
        r = '{sum: '0, cout: 1'b0, id: '0, ovf: 1'b0, lat: -1};
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                r.lat  = k;
                r.sum  = bus.rsp_sum;
                r.cout = bus.rsp_cout;
                r.id   = bus.rsp_id;
`ifdef ADDER_SCHED_OVF_EN
                r.ovf  = bus.rsp_ovf;
`endif
                break;
            end
        end
        if (r.lat < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 40 cycles");
        end
    endtask

    task automatic run_one(input string tag, input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] esum, input logic ecout, input logic eovf);
        int   gid;
        rsp_t r;
        idle_inputs();
        load_req(id, a, b, cin);
        do_accept(gid);
        bus.req_valid = '0;
        check({tag, "_grant"}, 128'(gid), 128'(id));
        collect(r);
        check({tag, "_lat"}, 128'(r.lat), 128'(LAT));
        check({tag, "_sum"}, 128'(r.sum), 128'(esum));
        check({tag, "_cout"}, 128'(r.cout), 128'(ecout));
        check({tag, "_id"}, 128'(r.id), 128'(id));
`ifdef ADDER_SCHED_OVF_EN
        check({tag, "_ovf"}, 128'(r.ovf), 128'(eovf));
`else
        if (eovf === 1'bx) $display("unexpected unknown overflow flag");
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         tbl[5];
        rsp_t         r;
        rsp_t         rq[$];
        int           acc_id[$];
        int           acc_cyc[$];
        int           gid;
        logic [W:0]   e;
        logic [W-1:0] ra[NREQ];
        logic [W-1:0] rb[NREQ];
        logic [NREQ-1:0] rc;
        logic [W-1:0] a, b;
        logic         cin;
        int           id;

        tbl[0] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        tbl[1] = '{1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 64'h0001_0000_0001_0001, 1'b0, 1'b0};
        tbl[2] = '{3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[3] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        tbl[4] = '{1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0, 1'b0};

        // Reset state, with every requester asking so a leaking grant would show.
        idle_inputs();
        bus.req_valid = '1;
        #2;
        check("rst_req_ready", 128'(bus.req_ready), 128'd0);
        check("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        check("rst_rsp_id", 128'(bus.rsp_id), 128'd0);
        check("rst_rsp_sum", 128'(bus.rsp_sum), 128'd0);
        check("rst_rsp_cout", 128'(bus.rsp_cout), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
`ifdef ADDER_SCHED_OVF_EN
        check("rst_rsp_ovf", 128'(bus.rsp_ovf), 128'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++)
            run_one($sformatf("tbl%0d", v), tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].cin,
                    tbl[v].sum, tbl[v].cout, tbl[v].ovf);

        for (int n = 0; n < 40; n++) begin
            id  = int'($urandom_range(0, NREQ - 1));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = '1;
                1: b = ~a;
                2: begin a = {1'b0, {(W-1){1'b1}}}; b = W'($urandom_range(0, 3)); end
                default: ;
            endcase
            e = ref_sum(a, b, cin);
            run_one($sformatf("rnd%0d", n), id, a, b, cin, e[W-1:0], e[W], ref_ovf(a, b, cin));
        end

        // Round robin with every requester continuously valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
            rc[i] = 1'($urandom_range(0, 1));
            load_req(i, ra[i], rb[i], rc[i]);
        end
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                gid = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (bus.req_ready[i]) gid = i;
                acc_id.push_back(gid);
                acc_cyc.push_back(c);
            end
            if (bus.rsp_valid) begin
                r.sum  = bus.rsp_sum;
                r.cout = bus.rsp_cout;
                r.id   = bus.rsp_id;
                rq.push_back(r);
            end
            @(negedge clk);
        end
        check("rr_accept_count", 128'(acc_id.size() >= 5), 128'd1);
        for (int j = 0; j < 5 && j < acc_id.size(); j++)
            check($sformatf("rr_grant%0d", j), 128'(acc_id[j]), 128'(j % NREQ));
        for (int j = 1; j < 5 && j < acc_cyc.size(); j++)
            check($sformatf("rr_gap%0d", j), 128'(acc_cyc[j] - acc_cyc[j-1]), 128'(WORDS + 2));
        check("rr_rsp_count", 128'(rq.size() >= 4), 128'd1);
        for (int j = 0; j < rq.size(); j++) begin
            check($sformatf("rr_rsp_id%0d", j), 128'(rq[j].id), 128'(j % NREQ));
            e = ref_sum(ra[rq[j].id], rb[rq[j].id], rc[rq[j].id]);
            check($sformatf("rr_rsp_sum%0d", j), 128'(rq[j].sum), 128'(e[W-1:0]));
            check($sformatf("rr_rsp_cout%0d", j), 128'(rq[j].cout), 128'(e[W]));
        end

        // Back-pressure: RESP must hold while a second requester waits.
        do_reset();
        bus.rsp_ready = 1'b0;
        a = 64'hDEAD_BEEF_0123_4567;
        b = 64'h1111_2222_FEDC_BA98;
        e = ref_sum(a, b, 1'b0);
        load_req(1, a, b, 1'b0);
        do_accept(gid);
        bus.req_valid = '0;
        check("bp_grant", 128'(gid), 128'd1);
        collect(r);
        check("bp_lat", 128'(r.lat), 128'(LAT));
        load_req(3, 64'h5, 64'h7, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.rsp_valid), 128'd1);
            check("bp_sum", 128'(bus.rsp_sum), 128'(e[W-1:0]));
            check("bp_id", 128'(bus.rsp_id), 128'd1);
            check("bp_req_ready", 128'(bus.req_ready), 128'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 128'(bus.rsp_valid), 128'd0);
        check("bp_next_grant", 128'(bus.req_ready), 128'b1000);
        do_accept(gid);
        bus.req_valid = '0;
        collect(r);
        check("bp_next_id", 128'(r.id), 128'd3);
        check("bp_next_sum", 128'(r.sum), 128'd13);

        // Reset in the middle of RUN: pointer returns to 0, no stale response.
        load_req(2, 64'h1111_2222_3333_4444, 64'h1, 1'b0);
        do_accept(gid);
        check("mr_grant", 128'(gid), 128'd2);
        idle_inputs();
        load_req(1, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0);
        load_req(3, 64'h9, 64'h9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mr_busy_before", 128'(bus.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mr_req_ready", 128'(bus.req_ready), 128'd0);
        check("mr_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        check("mr_rsp_id", 128'(bus.rsp_id), 128'd0);
        check("mr_rsp_sum", 128'(bus.rsp_sum), 128'd0);
        check("mr_rsp_cout", 128'(bus.rsp_cout), 128'd0);
        check("mr_busy", 128'(bus.busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_accept(gid);
        bus.req_valid = '0;
        check("mr_first_grant", 128'(gid), 128'd1);
        collect(r);
        check("mr_lat", 128'(r.lat), 128'(LAT));
        check("mr_id", 128'(r.id), 128'd1);
        check("mr_sum", 128'(r.sum), 128'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
